alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Parametrised successor to the single-cycle datapath ALU. All logic/shift/compare ops finish in 1 cycle.
//  Adds iterative MULT/MULTU/DIV/DIVU writing the architectural HI/LO pair, plus MFHI/MFLO/MTHI/MTLO.
//  Sits in the EX stage; the controller stalls on in_ready=0 and writes back on out_valid.
// PARAMETERS
//  WIDTH     32              datapath width (even, >=8)
//  SHAMT_W   $clog2(WIDTH)   shift-amount width
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        synchronous, active-high
//  in_valid    in   1        op_code/operands valid this cycle
//  in_ready    out  1        unit can accept an op (IDLE)
//  op_code     in   5        operation select (table below)
//  src_a       in   WIDTH    Read_Data_1 (rs)
//  src_b       in   WIDTH    ALU-src mux output (rt/imm)
//  shamt       in   SHAMT_W  shift amount (instr[10:6])
//  out_valid   out  1        one-cycle pulse: result/zero/err valid
//  out_result  out  WIDTH    result
//  out_zero    out  1        src_a == src_b of the accepted op
//  out_err     out  1        undefined op_code
//  hi_q, lo_q  out  WIDTH    architectural HI/LO
// BEHAVIOUR
//  Op codes: 0x00 AND, 0x01 OR, 0x02 ADD, 0x03 XOR, 0x04 SLL, 0x06 SUB, 0x07 SLT (signed),
//   0x08 SRL, 0x09 SRA, 0x0A LUI (src_b << WIDTH/2), 0x0C NOR, 0x10 MULT, 0x11 MULTU,
//   0x12 DIV, 0x13 DIVU, 0x14 MFHI, 0x15 MFLO, 0x16 MTHI (HI<=src_a), 0x17 MTLO; others undefined.
//  ADD/SUB wrap modulo 2^WIDTH, no overflow trap. Shifts act on src_b by shamt; SRA sign-fills.
//  Reset: FSM=IDLE, in_ready=1, out_valid=0, out_result=0, out_zero=0, out_err=0, hi_q=lo_q=0.
//  Handshake: op accepted when in_valid && in_ready. Inputs are captured at acceptance; later changes ignored.
//  FSM IDLE -> (accept single-cycle op) IDLE; next cycle out_valid=1.
//   MT*: HI/LO updated on the cycle after acceptance, together with out_valid; out_result=src_a.
//   MF*: reads HI/LO as of acceptance.
//  IDLE -> (accept mul/div) ITER: in_ready=0 for WIDTH cycles, one radix-2 step per cycle.
//   MUL: shift-add on operand magnitudes. DIV: restoring divide on magnitudes.
//  ITER -> FIX (1 cycle): sign correction, HI/LO written -> IDLE; out_valid=1 that cycle.
//   out_result=LO. Accept to out_valid is WIDTH+1 cycles.
//  Signed mul: 2*WIDTH product negated if sign(a)!=sign(b); HI=upper, LO=lower.
//  Div results: LO=quotient (trunc toward zero), HI=remainder (sign of dividend).
//   Div by zero (DIV or DIVU): LO=all ones, HI=src_a, no error. DIV most-neg/-1: LO=most-neg, HI=0.
//  Undefined op: 1 cycle, out_result=0, out_err=1 with out_valid; HI/LO unchanged.
//  in_valid while in_ready=0: ignored (not queued). out_valid never asserts while in ITER.
//  reset during ITER/FIX: op aborted, no out_valid, HI/LO=0, in_ready=1 next cycle.
//  out_zero is captured at acceptance for every op, including mul/div.
// STRUCTURE
//  Package alu_pkg: op_code localparams (shared with ALU control decoder), FSM state enum IDLE/ITER/FIX.
//  Sub-module muldiv_iter: shared WIDTH-bit accumulator/remainder datapath plus step counter.
//   Interface: start, is_div, is_signed -> done, hi, lo.
//  Top holds the single-cycle ops, HI/LO registers and the handshake FSM.
// TESTING
//  Reset then ADD 0x7FFFFFFF+1 -> next cycle out_valid=1, out_result=0x80000000, out_zero=0.
//  SRA src_b=0xF0000000, shamt=4 -> 0xFF000000. SLT -1<1 -> 1. LUI 0x1234 -> 0x12340000.
//  MULT -3*5 -> in_ready=0 for 32 cycles, out_valid at +33; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//   DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
//   MFHI/MFLO then return these values.
//  in_valid held high during DIVU -> no extra acceptance; reset at cycle 10 of MULTU -> no out_valid, hi_q=lo_q=0.
//  op_code 0x1F -> out_err=1, out_result=0, HI/LO unchanged. MTHI 0xA5A5A5A5 then MFHI -> 0xA5A5A5A5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the sequential ALU and the ALU control decoder.
//   - op_code values for every operation the unit recognises
//   - FSM state encoding of the top-level handshake controller
//   - small decode helpers used by the top level
package alu_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_AND   = 5'h00;
   localparam logic [OP_W-1:0] OP_OR    = 5'h01;
   localparam logic [OP_W-1:0] OP_ADD   = 5'h02;
   localparam logic [OP_W-1:0] OP_XOR   = 5'h03;
   localparam logic [OP_W-1:0] OP_SLL   = 5'h04;
   localparam logic [OP_W-1:0] OP_SUB   = 5'h06;
   localparam logic [OP_W-1:0] OP_SLT   = 5'h07;
   localparam logic [OP_W-1:0] OP_SRL   = 5'h08;
   localparam logic [OP_W-1:0] OP_SRA   = 5'h09;
   localparam logic [OP_W-1:0] OP_LUI   = 5'h0A;
   localparam logic [OP_W-1:0] OP_NOR   = 5'h0C;
   localparam logic [OP_W-1:0] OP_MULT  = 5'h10;
   localparam logic [OP_W-1:0] OP_MULTU = 5'h11;
   localparam logic [OP_W-1:0] OP_DIV   = 5'h12;
   localparam logic [OP_W-1:0] OP_DIVU  = 5'h13;
   localparam logic [OP_W-1:0] OP_MFHI  = 5'h14;
   localparam logic [OP_W-1:0] OP_MFLO  = 5'h15;
   localparam logic [OP_W-1:0] OP_MTHI  = 5'h16;
   localparam logic [OP_W-1:0] OP_MTLO  = 5'h17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // accepting ops; single-cycle results appear the next cycle
      ITER = 2'd1,   // one radix-2 mul/div step per cycle
      FIX  = 2'd2    // sign correction, HI/LO write, result pulse
   } state_t;

   // Multi-cycle operations handled by muldiv_iter.
   function automatic logic op_is_muldiv(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Signed variants of the multi-cycle operations.
   function automatic logic op_is_signed_md(input logic [OP_W-1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

   // Division variants of the multi-cycle operations.
   function automatic logic op_is_div(input logic [OP_W-1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply / restoring divide on operand magnitudes.
//
// Ports
//   clk, reset         clock, synchronous active-high reset (aborts any operation)
//   start              load operands and begin WIDTH iterations (ignored while busy)
//   is_div, is_signed  operation kind, sampled with start
//   a, b               operands, sampled with start
//   done               high during the final iteration cycle; hi/lo are final from
//                      the following cycle until the next start
//   hi, lo             sign-corrected result (product halves, or remainder/quotient)
//
// One WIDTH-bit accumulator (partial product high half / partial remainder) and
// one WIDTH-bit shift register (multiplier bits / dividend bits -> quotient) are
// shared by both operations; only the per-step update differs.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             busy;
   logic [CNT_W-1:0] cnt;
   logic             div_op;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] a_raw;
   logic             neg_main;   // product or quotient must be negated
   logic             neg_rem;    // remainder takes the dividend's sign
   logic             div_zero;

   // Operand magnitudes at start.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   always_comb begin
      a_neg = is_signed & a[WIDTH-1];
      b_neg = is_signed & b[WIDTH-1];
      a_mag = a_neg ? (~a + 1'b1) : a;
      b_mag = b_neg ? (~b + 1'b1) : b;
   end

   // One iteration of each algorithm.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc_n, mul_sreg_n;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] div_acc_n, div_sreg_n;

   always_comb begin
      // Shift-add, LSB first: the 2W-bit {acc, sreg} shifts right each step.
      mul_sum    = {1'b0, acc} + (sreg[0] ? {1'b0, mag_b} : '0);
      mul_acc_n  = mul_sum[WIDTH:1];
      mul_sreg_n = {mul_sum[0], sreg[WIDTH-1:1]};
      // Restoring divide, MSB first: dividend bits leave sreg at the top while
      // quotient bits enter at the bottom.
      div_shift  = {acc, sreg[WIDTH-1]};
      div_diff   = div_shift - {1'b0, mag_b};
      div_ge     = (div_shift >= {1'b0, mag_b});
      div_acc_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_sreg_n = {sreg[WIDTH-2:0], div_ge};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= 1'b0;
         cnt      <= '0;
         div_op   <= 1'b0;
         acc      <= '0;
         sreg     <= '0;
         mag_b    <= '0;
         a_raw    <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
      end else if (start && !busy) begin
         busy     <= 1'b1;
         cnt      <= '0;
         div_op   <= is_div;
         acc      <= '0;
         sreg     <= a_mag;
         mag_b    <= b_mag;
         a_raw    <= a;
         neg_main <= a_neg ^ b_neg;
         neg_rem  <= a_neg;
         div_zero <= is_div && (b == '0);
      end else if (busy) begin
         acc  <= div_op ? div_acc_n  : mul_acc_n;
         sreg <= div_op ? div_sreg_n : mul_sreg_n;
         cnt  <= cnt + 1'b1;
         if (cnt == LAST) begin
            busy <= 1'b0;
         end
      end
   end

   assign done = busy && (cnt == LAST);

   // Sign correction. The most-negative / -1 quotient needs no special case:
   // its magnitude 2^(WIDTH-1) negates back onto itself.
   logic [2*WIDTH-1:0] prod, prod_fix;

   always_comb begin
      prod     = {acc, sreg};
      prod_fix = neg_main ? (~prod + 1'b1) : prod;
      hi       = prod_fix[2*WIDTH-1:WIDTH];
      lo       = prod_fix[WIDTH-1:0];
      if (div_op) begin
         if (div_zero) begin
            hi = a_raw;
            lo = '1;
         end else begin
            hi = neg_rem  ? (~acc + 1'b1)  : acc;
            lo = neg_main ? (~sreg + 1'b1) : sreg;
         end
      end
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: EX-stage ALU with single-cycle logic/shift/compare ops and an
// iterative MULT/MULTU/DIV/DIVU unit writing the architectural HI/LO pair.
//
// Ports
//   clk, reset   clock (rising edge), synchronous active-high reset
//   in_valid     op_code/src_a/src_b/shamt valid this cycle
//   in_ready     unit is IDLE and will accept an op
//   op_code      operation select (alu_pkg::OP_*)
//   src_a        rs operand
//   src_b        rt / immediate operand
//   shamt        shift amount
//   out_valid    one-cycle pulse: out_result/out_zero/out_err valid
//   out_result   result (LO for mul/div)
//   out_zero     src_a == src_b of the accepted op
//   out_err      op_code was undefined
//   hi_q, lo_q   architectural HI/LO
//
// Handshake: an op is accepted on a rising edge where in_valid && in_ready;
// operands are captured at that edge and later input changes are ignored.
// in_valid while in_ready is low is dropped, not queued. Each accepted op
// produces exactly one out_valid pulse: the next cycle for single-cycle ops,
// WIDTH+1 cycles after acceptance (the FIX cycle) for mul/div.
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    op_code,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_result,
   output logic               out_zero,
   output logic               out_err,
   output logic [WIDTH-1:0]   hi_q,
   output logic [WIDTH-1:0]   lo_q
);

   state_t state, state_next;

   logic             accept;
   logic             is_md;
   logic [WIDTH-1:0] alu_res;
   logic             alu_err;

   logic             valid_r;
   logic [WIDTH-1:0] result_r;
   logic             zero_r;
   logic             err_r;
   logic [WIDTH-1:0] hi_r, lo_r;

   logic             md_done;
   logic [WIDTH-1:0] md_hi, md_lo;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign is_md    = op_is_muldiv(op_code);

   // ---------------- handshake FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept && is_md) state_next = ITER;
         ITER:    if (md_done)         state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- single-cycle operations ----------------
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (op_code)
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_ADD:  alu_res = src_a + src_b;
         OP_XOR:  alu_res = src_a ^ src_b;
         OP_SLL:  alu_res = src_b << shamt;
         OP_SUB:  alu_res = src_a - src_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SRL:  alu_res = src_b >> shamt;
         OP_SRA:  alu_res = $signed(src_b) >>> shamt;
         OP_LUI:  alu_res = src_b << (WIDTH / 2);
         OP_NOR:  alu_res = ~(src_a | src_b);
         OP_MFHI: alu_res = hi_r;
         OP_MFLO: alu_res = lo_r;
         OP_MTHI: alu_res = src_a;
         OP_MTLO: alu_res = src_a;
         // Result comes from muldiv_iter in FIX.
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   // ---------------- iterative mul/div ----------------
   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk       (clk),
      .reset     (reset),
      .start     (accept && is_md),
      .is_div    (op_is_div(op_code)),
      .is_signed (op_is_signed_md(op_code)),
      .a         (src_a),
      .b         (src_b),
      .done      (md_done),
      .hi        (md_hi),
      .lo        (md_lo)
   );

   // ---------------- result and HI/LO registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r  <= 1'b0;
         result_r <= '0;
         zero_r   <= 1'b0;
         err_r    <= 1'b0;
         hi_r     <= '0;
         lo_r     <= '0;
      end else begin
         // Only single-cycle ops pulse from the register; mul/div pulse in FIX.
         valid_r <= accept && !is_md;
         if (accept) begin
            result_r <= alu_res;
            zero_r   <= (src_a == src_b);
            err_r    <= alu_err;
            if (op_code == OP_MTHI) hi_r <= src_a;
            if (op_code == OP_MTLO) lo_r <= src_a;
         end
         if (state == FIX) begin
            hi_r     <= md_hi;
            lo_r     <= md_lo;
            result_r <= md_lo;
         end
      end
   end

   // In FIX the corrected mul/div result is forwarded so HI/LO and out_result
   // change together with out_valid, matching the MTHI/MTLO timing. A reset in
   // that cycle suppresses the pulse because the op is being aborted.
   assign out_valid  = valid_r | ((state == FIX) && !reset);
   assign out_result = (state == FIX) ? md_lo : result_r;
   assign out_zero   = zero_r;
   assign out_err    = err_r;
   assign hi_q       = (state == FIX) ? md_hi : hi_r;
   assign lo_q       = (state == FIX) ? md_lo : lo_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   // Opcodes written out independently of the design package.
   localparam logic [4:0] C_AND = 5'h00, C_OR = 5'h01, C_ADD = 5'h02, C_XOR = 5'h03;
   localparam logic [4:0] C_SLL = 5'h04, C_SUB = 5'h06, C_SLT = 5'h07, C_SRL = 5'h08;
   localparam logic [4:0] C_SRA = 5'h09, C_LUI = 5'h0A, C_NOR = 5'h0C;
   localparam logic [4:0] C_MULT = 5'h10, C_MULTU = 5'h11, C_DIV = 5'h12, C_DIVU = 5'h13;
   localparam logic [4:0] C_MFHI = 5'h14, C_MFLO = 5'h15, C_MTHI = 5'h16, C_MTLO = 5'h17;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic [4:0]         op_code;
   logic [WIDTH-1:0]   src_a, src_b;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic [WIDTH-1:0]   out_result;
   logic               out_zero;
   logic               out_err;
   logic [WIDTH-1:0]   hi_q, lo_q;

   alu_muldiv_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op_code    (op_code),
      .src_a      (src_a),
      .src_b      (src_b),
      .shamt      (shamt),
      .out_valid  (out_valid),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_err    (out_err),
      .hi_q       (hi_q),
      .lo_q       (lo_q)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int               n_vec = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] m_hi = '0;
   logic [WIDTH-1:0] m_lo = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void ref_model(
      input  logic [4:0]  op,
      input  logic [31:0] a, b,
      input  logic [4:0]  sh,
      input  logic [31:0] hi_in, lo_in,
      output logic [31:0] res, hi_out, lo_out,
      output logic        err);
      longint      sa, sb;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0; err = 1'b0; hi_out = hi_in; lo_out = lo_in;
      case (op)
         C_AND:  res = a & b;
         C_OR:   res = a | b;
         C_ADD:  res = a + b;
         C_XOR:  res = a ^ b;
         C_SLL:  res = b << sh;
         C_SUB:  res = a - b;
         C_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
         C_SRL:  res = b >> sh;
         C_SRA:  res = 32'(sb >>> sh);
         C_LUI:  res = b << 16;
         C_NOR:  res = ~(a | b);
         C_MULT: begin
            p = 64'(sa * sb);
            hi_out = p[63:32]; lo_out = p[31:0]; res = lo_out;
         end
         C_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            hi_out = p[63:32]; lo_out = p[31:0]; res = lo_out;
         end
         C_DIV: begin
            if (b == 0) begin lo_out = '1; hi_out = a; end
            else begin lo_out = 32'(sa / sb); hi_out = 32'(sa % sb); end
            res = lo_out;
         end
         C_DIVU: begin
            if (b == 0) begin lo_out = '1; hi_out = a; end
            else begin lo_out = a / b; hi_out = a % b; end
            res = lo_out;
         end
         C_MFHI: res = hi_in;
         C_MFLO: res = lo_in;
         C_MTHI: begin hi_out = a; res = a; end
         C_MTLO: begin lo_out = a; res = a; end
         default: err = 1'b1;
      endcase
   endfunction

   // ---------------- driver ----------------
   // Starts and ends on a falling edge. hold keeps in_valid asserted while the
   // unit is busy (only meaningful for mul/div ops).
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit hold);
      logic [31:0] e_res, e_hi, e_lo, got_exp;
      logic        e_err;
      bit          md;
      int          waitc, lat, busy;
      waitc = 0;
      while (!in_ready && waitc < 100) begin
         @(negedge clk);
         waitc++;
      end
      if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      ref_model(op, a, b, sh, m_hi, m_lo, e_res, e_hi, e_lo, e_err);
      md = (op == C_MULT) || (op == C_MULTU) || (op == C_DIV) || (op == C_DIVU);
      exp_q.push_back(e_res);
      in_valid = 1'b1; op_code = op; src_a = a; src_b = b; shamt = sh;
      @(posedge clk);
      #1;
      // Scramble inputs after acceptance; the unit must have captured them.
      src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
      in_valid = hold;
      if (!hold) op_code = 5'($urandom);
      lat = 0; busy = 0;
      do begin
         @(negedge clk);
         lat++;
         if (!in_ready && !out_valid) busy++;
      end while (!out_valid && lat < 60);
      in_valid = 1'b0;
      check($sformatf("latency_op%0h", op), 64'(lat), md ? 64'(WIDTH + 1) : 64'd1);
      check($sformatf("busy_op%0h", op), 64'(busy), md ? 64'(WIDTH) : 64'd0);
      if (out_valid) begin
         got_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         check($sformatf("result_op%0h", op), 64'(out_result), 64'(got_exp));
         check($sformatf("zero_op%0h", op), {63'd0, out_zero}, {63'd0, a == b});
         check($sformatf("err_op%0h", op), {63'd0, out_err}, {63'd0, e_err});
         check($sformatf("hi_op%0h", op), 64'(hi_q), 64'(e_hi));
         check($sformatf("lo_op%0h", op), 64'(lo_q), 64'(e_lo));
      end else begin
         check($sformatf("out_valid_timeout_op%0h", op), {63'd0, out_valid}, 64'd1);
         void'(exp_q.pop_front());
      end
      m_hi = e_hi; m_lo = e_lo;
      @(negedge clk);
      check($sformatf("pulse_end_op%0h", op), {63'd0, out_valid}, 64'd0);
      check($sformatf("idle_op%0h", op), {63'd0, in_ready}, 64'd1);
      check($sformatf("hi_hold_op%0h", op), 64'(hi_q), 64'(m_hi));
      check($sformatf("lo_hold_op%0h", op), 64'(lo_q), 64'(m_lo));
   endtask

   // MULTU aborted by reset after 10 busy cycles.
   task automatic reset_abort();
      int pulses;
      in_valid = 1'b1; op_code = C_MULTU; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_busy", {63'd0, in_ready}, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi = '0; m_lo = '0;
      check("abort_ready", {63'd0, in_ready}, 64'd1);
      check("abort_hi", 64'(hi_q), 64'd0);
      check("abort_lo", 64'(lo_q), 64'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("abort_no_valid", 64'(pulses), 64'd0);
      check("abort_hi_late", 64'(hi_q), 64'd0);
   endtask

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- main sequence ----------------
   logic [4:0] op_list [19];

   initial begin
      op_list = '{C_AND, C_OR, C_ADD, C_XOR, C_SLL, C_SUB, C_SLT, C_SRL, C_SRA, C_LUI,
                  C_NOR, C_MULT, C_MULTU, C_DIV, C_DIVU, C_MFHI, C_MFLO, C_MTHI, C_MTLO};
      reset = 1'b1; in_valid = 1'b0; op_code = '0; src_a = '0; src_b = '0; shamt = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_result", 64'(out_result), 64'd0);
      check("rst_zero", {63'd0, out_zero}, 64'd0);
      check("rst_err", {63'd0, out_err}, 64'd0);
      check("rst_hi", 64'(hi_q), 64'd0);
      check("rst_lo", 64'(lo_q), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      run_op(C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
      run_op(C_SRA,  32'h0000_0000, 32'hF000_0000, 5'd4, 1'b0);
      run_op(C_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
      run_op(C_LUI,  32'h0000_0000, 32'h0000_1234, 5'd0, 1'b0);
      run_op(C_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 5'd0, 1'b0);
      run_op(C_MFHI, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0);
      run_op(C_MFLO, 32'h0000_0003, 32'h0000_0003, 5'd0, 1'b0);
      run_op(C_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 5'd0, 1'b0);
      run_op(C_MFHI, 32'h0000_0000, 32'h0000_0001, 5'd0, 1'b0);
      run_op(C_MFLO, 32'h0000_0000, 32'h0000_0001, 5'd0, 1'b0);
      run_op(C_DIVU, 32'h0000_0007, 32'h0000_0000, 5'd0, 1'b1);
      run_op(C_MFHI, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0);
      run_op(C_MFLO, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0);
      run_op(C_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
      run_op(C_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 5'd0, 1'b0);
      run_op(5'h1F,  32'h0000_1111, 32'h0000_2222, 5'd0, 1'b0);
      run_op(C_MTHI, 32'hA5A5_A5A5, 32'h0000_0000, 5'd0, 1'b0);
      run_op(C_MFHI, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0);
      run_op(C_MTLO, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 5'd0, 1'b0);
      run_op(C_MFLO, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0);

      reset_abort();

      for (int i = 0; i < 80; i++) begin
         logic [4:0] op;
         if ($urandom_range(0, 9) == 0) op = 5'($urandom);
         else op = op_list[$urandom_range(0, 18)];
         run_op(op, pick_val(), pick_val(), 5'($urandom), 1'($urandom_range(0, 1)) &
                ((op == C_MULT) || (op == C_MULTU) || (op == C_DIV) || (op == C_DIVU)));
      end

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Run-length guard.
   initial begin
      #2_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
